// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters,
// with per-grant bursts ended by req_last, by MAX_BURST, or by the owner withdrawing req_valid.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 syncReset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_busy,
  input  logic                 tx_done
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, pick_idx, next_idx;
  logic [IW-1:0]   cand [NUM_REQ];
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic            last_q, last_d;
  logic [NUM_REQ-1:0] gsel;
  // Candidates in priority order starting at rr_ptr; scanning backwards leaves the nearest valid one.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) cand[k] = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
    pick_idx = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) pick_idx = req_valid[cand[k]] ? cand[k] : pick_idx;
  end
  assign next_idx = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign gsel     = NUM_REQ'(1) << gidx_q;
  assign active   = (state_q != IDLE);
  assign grant    = active ? gsel : '0;
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    req_ready   = '0;
    req_done    = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gidx_d      = pick_idx;
          burst_cnt_d = 8'h00;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!req_valid[gidx_q]) begin
          rr_ptr_d = next_idx;
          state_d  = IDLE;
        end else if (!tx_busy) begin
          tx_valid    = 1'b1;
          tx_data     = req_data[{gidx_q, 3'b000} +: 8];
          req_ready   = gsel;
          last_d      = req_last[gidx_q];
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          req_done = gsel;
          rr_ptr_d = (last_q || burst_cnt_q == 8'(MAX_BURST)) ? next_idx : rr_ptr_q;
          state_d  = (last_q || burst_cnt_q == 8'(MAX_BURST)) ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      burst_cnt_q <= 8'h00;
      last_q      <= 1'b0;
    end else if (syncReset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      burst_cnt_q <= 8'h00;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: rule-based scoreboard of the arbiter against per-requester byte queues,
// a behavioural transmitter, and randomized traffic plus the directed scenarios.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  logic clk = 1'b0, nReset, syncReset;
  logic [N-1:0] req_valid, req_last, req_ready, req_done, grant;
  logic [N*8-1:0] req_data;
  logic active, tx_valid, tx_busy, tx_done;
  logic [7:0] tx_data;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .nReset(nReset), .syncReset(syncReset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .req_done(req_done), .grant(grant), .active(active),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  int n_chk = 0, n_pass = 0;
  logic [8:0] src [N][$];
  logic [8:0] exp_q [N][$];
  bit pop [N], hold_off [N];
  bit force_busy = 0, launch_seen = 0, srst_pulse = 0, rst_seen = 0;
  int tx_cnt = 0, frame_len = 0;
  int rr = 0, out = -1, cnt = 0, po = -1;
  bit lastf = 0, rel_next = 0, wd_next = 0;
  logic [N-1:0] pg = '0, pv = '0;
  int glog[$];
  int done_cnt [N], rdy_cnt [N];
  int launches = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  function automatic int pick(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int total(bit use_exp);
    int s = 0;
    for (int i = 0; i < N; i++) s += use_exp ? exp_q[i].size() : src[i].size();
    return s;
  endfunction

  task automatic push(int i, logic last, logic [7:0] d);
    src[i].push_back({last, d});
    exp_q[i].push_back({last, d});
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      exp_q[i].delete();
      pop[i] = 0;
      hold_off[i] = 0;
    end
  endtask

  task automatic clear_stats();
    glog.delete();
    launches = 0;
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      rdy_cnt[i] = 0;
    end
  endtask

  // Expectations are derived from arbitration rules on observed history, not from a state machine copy.
  task automatic monitor();
    int o = -1;
    int os;
    bit send;
    logic [N-1:0] eg, ed;
    if (!nReset || rst_seen) begin
      chk("rst_grant", grant, 0);
      chk("rst_active", active, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", req_done, 0);
      out = -1; rr = 0; pg = '0; rel_next = 0; wd_next = 0; pv = req_valid;
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (grant[i]) o = i;
    chk("onehot", $onehot0(grant), 1);
    chk("active", active, |grant);
    if (pg == 0) eg = (pv != 0) ? N'(1) << pick(rr, pv) : '0;
    else eg = (rel_next || wd_next) ? '0 : pg;
    chk("grant", grant, eg);
    if (pg != 0 && grant == 0) rr = (po + 1) % N;
    if (pg == 0 && grant != 0) begin
      cnt = 0;
      glog.push_back(o);
    end
    os = out;
    send = (o >= 0) && (os < 0);
    chk("launch", tx_valid, send && req_valid[o] && !tx_busy);
    chk("ready", req_ready, tx_valid ? grant : '0);
    if (tx_valid) begin
      launch_seen = 1;
      launches++;
      if (o >= 0 && exp_q[o].size() > 0) begin
        chk("data", tx_data, exp_q[o][0][7:0]);
        lastf = exp_q[o][0][8];
        exp_q[o].delete(0);
        out = o;
        cnt++;
      end else chk("unexpected_launch", tx_valid, 0);
    end else chk("idle_data", tx_data, 0);
    for (int i = 0; i < N; i++) if (req_ready[i]) begin
      pop[i] = 1;
      rdy_cnt[i]++;
    end
    ed = (tx_done && os >= 0) ? N'(1) << os : '0;
    chk("done", req_done, ed);
    rel_next = 0;
    if (tx_done && os >= 0) begin
      done_cnt[os]++;
      rel_next = lastf || cnt == MB;
      out = -1;
    end
    wd_next = send && !req_valid[o];
    pg = grant; po = o; pv = req_valid;
  endtask

  task automatic step();
    @(posedge clk);
    rst_seen = syncReset || !nReset;
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) begin
      if (src[i].size() > 0) src[i].delete(0);
      pop[i] = 0;
    end
    tx_done = 0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      tx_done = (tx_cnt == 0);
    end
    if (launch_seen) begin
      tx_cnt = (frame_len > 0) ? frame_len : int'($urandom_range(1, 4));
      launch_seen = 0;
    end
    tx_busy = force_busy || tx_cnt > 0;
    syncReset = srst_pulse;
    srst_pulse = 0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src[i].size() > 0 && !hold_off[i];
      {req_last[i], req_data[i*8 +: 8]} = req_valid[i] ? src[i][0] : 9'h0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until_idle(int maxc);
    int c = 0;
    while (!(total(0) == 0 && grant == 0 && tx_cnt == 0 && out < 0) && c < maxc) begin
      step();
      c++;
    end
    chk("idle_timeout", c < maxc, 1);
    chk("drained", total(1), 0);
  endtask

  task automatic sreset();
    clear_all();
    srst_pulse = 1;
    step();
    step();
    clear_stats();
  endtask

  task automatic wait_launch();
    int c = 0;
    while (launches == 0 && c < 30) begin
      step();
      c++;
    end
    chk("launch_timeout", launches > 0, 1);
  endtask

  initial begin
    int exp_burst [4] = '{2, 1, 2, 2};
    nReset = 0; syncReset = 0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 0; tx_done = 0;
    clear_all();
    clear_stats();
    step();
    step();
    nReset = 1;
    push(0, 1, 8'hA5);
    run_until_idle(50);
    chk("single_owner", glog.size() > 0 ? glog[0] : -1, 0);
    chk("single_done", done_cnt[0], 1);
    chk("single_launches", launches, 1);
    chk("single_grant_end", grant, 0);
    chk("single_active_end", active, 0);
    sreset();
    for (int i = 0; i < N; i++) begin
      push(i, 1, 8'h10 + 8'(i));
      push(i, 1, 8'h20 + 8'(i));
    end
    run_until_idle(300);
    chk("fair_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("fair_order", glog[k], k % N);
    for (int i = 0; i < N; i++) chk("fair_ready", rdy_cnt[i], 2);
    sreset();
    for (int b = 0; b < 10; b++) push(2, 0, 8'(b));
    repeat (3) step();
    push(1, 1, 8'h55);
    run_until_idle(400);
    chk("burst_grants", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("burst_order", glog[k], exp_burst[k]);
    chk("burst_ready2", rdy_cnt[2], 10);
    sreset();
    force_busy = 1;
    push(1, 1, 8'h3C);
    repeat (20) step();
    chk("hold_launches", launches, 0);
    chk("hold_grant", grant, 4'b0010);
    force_busy = 0;
    step();
    chk("hold_release", launches, 1);
    run_until_idle(50);
    sreset();
    force_busy = 1;
    push(3, 1, 8'h77);
    step();
    step();
    chk("wd_granted", grant, 4'b1000);
    hold_off[3] = 1;
    step();
    step();
    chk("wd_grant", grant, 0);
    chk("wd_launches", launches, 0);
    hold_off[3] = 0;
    force_busy = 0;
    push(0, 1, 8'h11);
    glog.delete();
    run_until_idle(100);
    chk("wd_next_owner", glog.size() > 0 ? glog[0] : -1, 0);
    sreset();
    frame_len = 6;
    push(0, 0, 8'hC1);
    push(0, 1, 8'hC2);
    wait_launch();
    step();
    clear_all();
    srst_pulse = 1;
    step();
    step();
    repeat (8) step();
    chk("srst_no_done", done_cnt[0], 0);
    run_until_idle(50);
    sreset();
    push(2, 0, 8'hD1);
    push(2, 1, 8'hD2);
    wait_launch();
    step();
    #2 nReset = 0;
    #1 monitor();
    clear_all();
    step();
    nReset = 1;
    repeat (8) step();
    chk("arst_no_done", done_cnt[2], 0);
    frame_len = 0;
    run_until_idle(50);
    sreset();
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        int i = int'($urandom_range(0, N - 1));
        int n = int'($urandom_range(1, 6));
        bit l = 1'($urandom_range(0, 1));
        if (src[i].size() < 8)
          for (int b = 0; b < n; b++) push(i, l && b == n - 1, 8'($urandom));
      end
      force_busy = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) hold_off[i] = ($urandom_range(0, 31) == 0);
      step();
    end
    force_busy = 0;
    for (int i = 0; i < N; i++) hold_off[i] = 0;
    run_until_idle(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `UartTxEn` transmitter among `NUM_REQ` byte requesters. Each requester presents bytes over a valid/ready handshake and may hold the transmitter for a burst ended by `req_last` or by `MAX_BURST`. The block drives the transmitter's `data`/`valid` inputs and sequences frames using its `busy`/`done` outputs. It sits between client logic, such as the AHB register front end and debug sources, and the TX half of the UART datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes per grant, 1..255.
- `clk` in 1: system clock.
- `nReset` in 1: asynchronous active-low reset.
- `syncReset` in 1: synchronous reset, same effect as `nReset`.
- `req_valid` in NUM_REQ: byte available, one bit per requester.
- `req_data` in NUM_REQ×8: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` in NUM_REQ: the presented byte ends this requester's burst.
- `req_ready` out NUM_REQ: one-hot pulse; byte accepted this cycle.
- `req_done` out NUM_REQ: one-hot pulse; the accepted byte finished on the line.
- `grant` out NUM_REQ: one-hot current owner; 0 when idle.
- `active` out 1: a grant is held.
- `tx_data` out 8: to `UartTxEn.data`.
- `tx_valid` out 1: to `UartTxEn.valid`.
- `tx_busy` in 1: from `UartTxEn.busy`.
- `tx_done` in 1: from `UartTxEn.done`.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE**
  - If `req_valid` is nonzero, pick the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Register that bit as `grant` and clear `burst_cnt`. Go to SEND.
- **SEND**
  - Let g be the granted requester.
  - If `req_valid[g]`=1 and `tx_busy`=0:
    - Assert `tx_valid`=1, `tx_data`=`req_data[g]`, `req_ready[g]`=1 in the same cycle (combinational).
    - Latch `last_q`=`req_last[g]`, increment `burst_cnt` (8-bit), go to WAIT.
  - If `req_valid[g]`=1 and `tx_busy`=1: hold in SEND and drive no outputs.
  - If `req_valid[g]`=0: release the grant, set `rr_ptr`=(g+1) mod NUM_REQ, go to IDLE.
- **WAIT**
  - On `tx_done`=1, pulse `req_done[g]`=1 for that cycle.
  - Then, if `last_q`=1 or `burst_cnt`==MAX_BURST, release: `rr_ptr`=(g+1) mod NUM_REQ, go to IDLE.
  - Otherwise go to SEND and keep the grant.
- `tx_data` is 0 whenever `tx_valid`=0.
- `req_ready` and `req_done` are never set for a requester that is not granted.
- Requester contract: once `req_valid[i]` is raised, `req_data[i]` and `req_last[i]` stay stable until `req_ready[i]`. The arbiter does not check this.

## Timing
- Reset values (both `nReset` and `syncReset`):
  - State IDLE, `rr_ptr`=0, `grant`=0, `active`=0, `burst_cnt`=0, `last_q`=0.
  - All pulse outputs 0, `tx_valid`=0, `tx_data`=0.
- Arbitration latency: `req_valid` rising in cycle t gives `grant` in t+1 and the earliest `tx_valid`/`req_ready` in t+1.
- Exactly one `tx_valid` cycle per byte. `tx_valid` is never asserted while `tx_busy`=1.
- Byte-to-byte gap inside a burst: `tx_done` in cycle d gives the next `tx_valid` no earlier than d+1.
- Release to the next owner: `tx_done` in cycle d (IDLE at d+1) gives a new `grant` at d+2.
- `tx_done` outside WAIT is ignored. This covers a frame still completing after a mid-frame reset, which must not produce `req_done`.
- Reset asserted mid-burst drops the grant immediately. The interrupted byte's `req_done` is never issued.
- If `req_valid` and `req_last` are both high in the same SEND cycle, that byte is sent and the grant is released after its `tx_done`.
- `MAX_BURST`=1 degenerates to per-byte round robin.
- Round-robin wrap: after requester NUM_REQ−1 releases, `rr_ptr`=0.

## Test plan
- **Single byte:** req 0 sends 0xA5 with `last`. Expect `tx_valid` one cycle with `tx_data`=0xA5, then `req_done[0]` on `tx_done`, then `grant`=0 and `active`=0.
- **Fairness:** all 4 requesters hold `valid` with `last`=1. Grants run in order 0,1,2,3,0. Each `req_ready` pulses once per grant.
- **Burst cap:** `MAX_BURST`=4; req 2 streams 10 bytes 0x00..0x09 with `last`=0, req 1 also pending. Expect bytes 0x00..0x03, then req 1, then req 2 resumes at 0x04.
- **Busy hold:** `tx_busy` forced high for 20 cycles in SEND. No `tx_valid`, no `req_ready`; the byte launches on the first cycle `busy`=0.
- **Withdraw:** req 3 granted, then `req_valid[3]` drops before launch. Expect return to IDLE with `rr_ptr`=0 and no `tx_valid`.
- **Mid-frame reset:** pulse `syncReset` in WAIT, then inject `tx_done`. Outputs return to reset values and no `req_done` fires. Repeat with `nReset` asserted asynchronously mid-cycle.
